// File: rtl/sha256_compress_core.sv
// ============================================================================
// Module  : sha256_compress_core
// Brief   : Iterative SHA-256 compression, ROUNDS_PER_CYCLE rounds per clock.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sha256_compress_core #(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter int WORD_W           = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         use_iv,
  input  logic [511:0] block_in,
  input  logic [255:0] chain_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] digest_out,
  output logic         busy
);

  if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4 ||
        ROUNDS_PER_CYCLE == 8 || ROUNDS_PER_CYCLE == 16)) begin : g_bad_rounds
    $error("sha256_compress_core: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end
  if (WORD_W != 32) begin : g_bad_word_w
    $error("sha256_compress_core: WORD_W must be 32");
  end

  localparam int        c_R      = ROUNDS_PER_CYCLE;
  localparam logic [5:0] c_T_STEP = 6'(c_R);
  localparam logic [5:0] c_T_LAST = 6'(64 - c_R);

  localparam logic [0:7][31:0] c_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam logic [0:63][31:0] c_K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_s0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_s1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] choice(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) | (~x & z);
  endfunction

  function automatic logic [31:0] majority(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [0:7][31:0]   hv_q, hv_d;      // chaining state H0..H7
  logic [0:7][31:0]   wk_q, wk_d;      // working regs a..h
  logic [0:15][31:0]  win_q, win_d;    // win_q[0] holds W[t]
  logic [5:0]         t_q, t_d;
  logic [255:0]       digest_q, digest_d;

  // Window extended by R freshly scheduled words; round j consumes w_ext[j].
  logic [31:0]        w_ext [16 + c_R];
  logic [0:7][31:0]   w_st  [c_R + 1];

  for (genvar i = 0; i < 16; i++) begin : g_win
    assign w_ext[i] = win_q[i];
  end

  for (genvar k = 0; k < c_R; k++) begin : g_sched
    assign w_ext[16 + k] = small_s1(w_ext[14 + k]) + w_ext[9 + k] +
                           small_s0(w_ext[1 + k]) + w_ext[k];
  end

  assign w_st[0] = wk_q;

  for (genvar j = 0; j < c_R; j++) begin : g_round
    logic [31:0] w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h, w_t1, w_t2;
    logic [5:0]  w_idx;
    assign {w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h} = w_st[j];
    assign w_idx = t_q + 6'(j);
    assign w_t1  = w_h + big_s1(w_e) + choice(w_e, w_f, w_g) + c_K[w_idx] + w_ext[j];
    assign w_t2  = big_s0(w_a) + majority(w_a, w_b, w_c);
    assign w_st[j + 1] = {w_t1 + w_t2, w_a, w_b, w_c, w_d + w_t1, w_e, w_f, w_g};
  end

  always_comb begin
    state_d  = state_q;
    hv_d     = hv_q;
    wk_d     = wk_q;
    win_d    = win_q;
    t_d      = t_q;
    digest_d = digest_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_ROUND;
          t_d     = '0;
          for (int i = 0; i < 8; i++) begin
            hv_d[i] = use_iv ? c_IV[i] : chain_in[255 - 32*i -: 32];
          end
          wk_d = hv_d;
          for (int i = 0; i < 16; i++) begin
            win_d[i] = block_in[511 - 32*i -: 32];
          end
        end
      end
      ST_ROUND: begin
        wk_d = w_st[c_R];
        for (int i = 0; i < 16; i++) begin
          win_d[i] = w_ext[i + c_R];
        end
        t_d = t_q + c_T_STEP;
        if (t_q == c_T_LAST) begin
          state_d = ST_DONE;
          for (int i = 0; i < 8; i++) begin
            digest_d[255 - 32*i -: 32] = hv_q[i] + w_st[c_R][i];
          end
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      hv_q     <= '0;
      wk_q     <= '0;
      win_q    <= '0;
      t_q      <= '0;
      digest_q <= '0;
    end else begin
      state_q  <= state_d;
      hv_q     <= hv_d;
      wk_q     <= wk_d;
      win_q    <= win_d;
      t_q      <= t_d;
      digest_q <= digest_d;
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_DONE);
  assign busy       = (state_q != ST_IDLE);
  assign digest_out = digest_q;

endmodule

`default_nettype wire

// File: tb/tb_sha256_compress_core.sv
// ============================================================================
// Module  : tb_sha256_compress_core
// Brief   : Bench for sha256_compress_core, one lane per legal ROUNDS_PER_CYCLE.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sha256_compress_core;

  localparam int c_LANES = 5;

  logic         clk;
  logic         rst_n;
  logic         in_valid   [c_LANES];
  logic         in_ready   [c_LANES];
  logic         use_iv     [c_LANES];
  logic [511:0] block_in   [c_LANES];
  logic [255:0] chain_in   [c_LANES];
  logic         out_valid  [c_LANES];
  logic         out_ready  [c_LANES];
  logic [255:0] digest_out [c_LANES];
  logic         busy       [c_LANES];

  for (genvar g = 0; g < c_LANES; g++) begin : g_dut
    sha256_compress_core #(.ROUNDS_PER_CYCLE(1 << g), .WORD_W(32)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid[g]),
      .in_ready   (in_ready[g]),
      .use_iv     (use_iv[g]),
      .block_in   (block_in[g]),
      .chain_in   (chain_in[g]),
      .out_valid  (out_valid[g]),
      .out_ready  (out_ready[g]),
      .digest_out (digest_out[g]),
      .busy       (busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [255:0] c_IV256 =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Whole-message-schedule reference: expand all 64 words, then run 64 rounds.
  function automatic logic [255:0] ref_compress(input logic [255:0] ch, input logic [511:0] blk);
    logic [31:0]  w  [64];
    logic [31:0]  v  [8];
    logic [31:0]  hv [8];
    logic [31:0]  t1, t2;
    logic [255:0] res;
    for (int i = 0; i < 8; i++) begin
      hv[i] = ch[255 - 32*i -: 32];
      v[i]  = hv[i];
    end
    for (int i = 0; i < 64; i++) begin
      if (i < 16) w[i] = blk[511 - 32*i -: 32];
      else        w[i] = (rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7] +
                         (rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    end
    for (int i = 0; i < 64; i++) begin
      t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) | (~v[4] & v[6])) + KT[i] + w[i];
      t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]));
      for (int k = 7; k > 0; k--) v[k] = v[k-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) res[255 - 32*i -: 32] = hv[i] + v[i];
    return res;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Present one block on lane ln, wait for the digest, optionally stall the
  // output (with a spurious in_valid pulse), then complete the handshake.
  task automatic run_block(input int ln, input bit iv, input logic [255:0] ch,
                           input logic [511:0] blk, input int stall, input bit pulse,
                           output logic [255:0] dig, output int lat);
    int guard;
    @(negedge clk);
    use_iv[ln] = iv; chain_in[ln] = ch; block_in[ln] = blk; in_valid[ln] = 1'b1;
    guard = 0;
    while (!in_ready[ln] && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    in_valid[ln] = 1'b0;
    use_iv[ln]   = 1'($urandom);
    chain_in[ln] = rand256();
    block_in[ln] = rand512();
    lat = 1;
    while (!out_valid[ln] && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    chk($sformatf("out_valid_arrives_l%0d", ln), {255'b0, out_valid[ln]}, 256'd1);
    dig = digest_out[ln];
    for (int s = 0; s < stall; s++) begin
      if (pulse && s == 2) begin
        in_valid[ln] = 1'b1; block_in[ln] = rand512(); use_iv[ln] = 1'b1;
      end
      if (pulse && s == 5) in_valid[ln] = 1'b0;
      @(negedge clk);
      chk($sformatf("stall_digest_l%0d_s%0d", ln, s), digest_out[ln], dig);
      chk($sformatf("stall_ready_l%0d_s%0d", ln, s), {254'b0, out_valid[ln], in_ready[ln]}, 256'b10);
    end
    in_valid[ln]  = 1'b0;
    out_ready[ln] = 1'b1;
    @(negedge clk);
    out_ready[ln] = 1'b0;
    chk($sformatf("post_handshake_l%0d", ln), {253'b0, out_valid[ln], in_ready[ln], busy[ln]}, 256'b010);
  endtask

  localparam logic [511:0] c_BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] c_BLK_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] c_BLK_TWO1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                          32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                          32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                          32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] c_BLK_TWO2  = {480'h0, 32'h000001c0};
  localparam logic [255:0] c_DIG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] c_DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] c_DIG_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  initial begin
    logic [255:0] dig, dig1, ch, exp_dig;
    logic [511:0] blk;
    int           lat, stray, r;
    bit           iv;

    for (int i = 0; i < c_LANES; i++) begin
      in_valid[i] = 1'b0; use_iv[i] = 1'b0; out_ready[i] = 1'b0;
      block_in[i] = '0;   chain_in[i] = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < c_LANES; i++) begin
      chk($sformatf("reset_ctrl_l%0d", i), {253'b0, in_ready[i], out_valid[i], busy[i]}, 256'b100);
      chk($sformatf("reset_digest_l%0d", i), digest_out[i], 256'h0);
    end
    rst_n = 1'b1;

    run_block(0, 1'b1, rand256(), c_BLK_ABC, 0, 1'b0, dig, lat);
    chk("abc_digest", dig, c_DIG_ABC);
    chk("abc_latency", 256'(lat), 256'd65);
    chk("abc_digest_held_idle", digest_out[0], c_DIG_ABC);

    for (int ln = 0; ln < c_LANES; ln++) begin
      r = 1 << ln;
      run_block(ln, 1'b1, '0, c_BLK_EMPTY, 0, 1'b0, dig, lat);
      chk($sformatf("empty_digest_r%0d", r), dig, c_DIG_EMPTY);
      chk($sformatf("empty_latency_r%0d", r), 256'(lat), 256'(64 / r + 1));
    end

    for (int ln = 0; ln < c_LANES; ln += 2) begin
      run_block(ln, 1'b1, rand256(), c_BLK_TWO1, 0, 1'b0, dig1, lat);
      chk($sformatf("two_block1_l%0d", ln), dig1, ref_compress(c_IV256, c_BLK_TWO1));
      run_block(ln, 1'b0, dig1, c_BLK_TWO2, 0, 1'b0, dig, lat);
      chk($sformatf("two_block2_l%0d", ln), dig, c_DIG_TWO);
    end

    // Output stall with a spurious in_valid pulse that must be dropped.
    run_block(1, 1'b1, '0, c_BLK_ABC, 10, 1'b1, dig, lat);
    chk("stall_digest_value", dig, c_DIG_ABC);
    stray = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (out_valid[1] || busy[1]) stray++;
    end
    chk("stall_pulse_ignored", 256'(stray), 256'd0);

    // Asynchronous reset in the middle of ROUND.
    @(negedge clk);
    use_iv[0] = 1'b1; block_in[0] = rand512(); in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (20) @(negedge clk);
    chk("pre_abort_busy", {255'b0, busy[0]}, 256'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_ctrl", {253'b0, in_ready[0], out_valid[0], busy[0]}, 256'b100);
    chk("abort_digest", digest_out[0], 256'h0);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (out_valid[0]) stray++;
    end
    chk("abort_no_stale_output", 256'(stray), 256'd0);

    // Randomized blocks against the reference model.
    for (int ln = 0; ln < c_LANES; ln++) begin
      r = 1 << ln;
      for (int b = 0; b < ((ln == 0) ? 10 : 25); b++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        iv  = 1'($urandom);
        ch  = rand256();
        blk = rand512();
        exp_dig = ref_compress(iv ? c_IV256 : ch, blk);
        run_block(ln, iv, ch, blk, int'($urandom_range(0, 3)), 1'b0, dig, lat);
        chk($sformatf("rand_digest_r%0d_b%0d", r, b), dig, exp_dig);
        chk($sformatf("rand_latency_r%0d_b%0d", r, b), 256'(lat), 256'(64 / r + 1));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
